if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage: owns the PC and fetches 32-bit little-endian instructions over the shared 8-bit memory port, one byte per granted cycle.
- Feeds if_id with (pc, inst); raises a stall request while a fetch is incomplete.
- Accepts branch redirects from ID.
- Contains a small direct-mapped instruction cache so that hits complete without using memory.

Parameters:
- ICACHE_IDX_W, 5, log2 of cache entries (32 entries, 1 word each).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- stall_i  input  6  pipeline stall vector from the stall controller; bit 0 = PC/IF hold (`Stop` = 1).
- branch_flag_i  input  1  redirect request from ID.
- branch_target_i  input  32  redirect target.
- mem_busy_i  input  1  MEM stage owns the memory port this cycle; IF must not issue.
- mem_din_i  input  8  read byte; valid the cycle after a granted issue.
- mem_req_o  output  1  IF issues a byte read this cycle.
- mem_addr_o  output  32  byte address of the issue.
- if_pc_o  output  32  PC of the presented instruction.
- if_inst_o  output  32  instruction word, or 0 when not ready.
- stallreq_o  output  1  fetch incomplete; stall controller must stop stages 0–1.

Behaviour:
- Reset: pc=RESET_PC; state=S0; byte buffer=0; in-flight flag=0; all cache valid bits=0.
- Outputs during reset cycle: mem_req_o=0, mem_addr_o=0, if_pc_o=0, if_inst_o=0, stallreq_o=0.
- Cache lookup:
  - Index = pc[ICACHE_IDX_W+1:2]; tag = pc[31:ICACHE_IDX_W+2].
  - Lookup is combinational and occurs only in S0.
- States: S0, S1, S2, S3, S4, DONE. In Sk (k = 0..3), byte k is issued at pc+k.
- S0, cache hit:
  - if_inst_o = cached word, if_pc_o = pc, stallreq_o=0, no memory issue.
  - If stall_i[0]=0: pc <= pc+4 and stay in S0.
- S0, cache miss, and every S1..S3:
  - If mem_busy_i=0: mem_req_o=1, mem_addr_o = pc + k; set in-flight; advance to the next state.
  - If mem_busy_i=1: mem_req_o=0, state holds, in-flight clears.
- Byte capture:
  - In any cycle where in-flight is set, mem_din_i is written to buffer byte (state index − 1), independent of mem_busy_i.
  - S4 issues nothing. It captures byte 3 when in-flight is set, then goes to DONE.
- DONE:
  - if_inst_o = {b3,b2,b1,b0}, if_pc_o = pc, stallreq_o=0.
  - The cache entry is written on the DONE entry cycle.
  - If stall_i[0]=0: pc <= pc+4, go to S0. Otherwise hold DONE with outputs stable.
- stallreq_o=1 in S0-miss and in S1..S4; if_inst_o=0 and if_pc_o=pc in those states.
- Fetch latency with no contention:
  - Miss: 6 cycles from S0 to DONE (S0–S4, then DONE).
  - Hit: 0 extra cycles.
- Branch redirect:
  - branch_flag_i=1 in any state: pc <= branch_target_i, state <= S0, in-flight cleared.
  - The returning byte is discarded and no cache write occurs.
  - Redirect overrides stall_i[0].
- Priority: rst > branch_flag_i > stall_i[0] > normal progression.
- Width rules:
  - pc+k and pc+4 wrap modulo 2^32.
  - A misaligned branch target is fetched as-is; the cache index ignores pc[1:0].
  - The cache stores a word only when pc[1:0]=0.
- Reset mid-fetch: the fetch is abandoned and the cache is invalidated; the next cycle is S0 at RESET_PC.

Decomposition:
- Shared package/define file: `RstEnable`, `Stop`/`NoStop`, `ZeroWord`, `InstAddrBus`/`InstBus` widths, state encodings for S0..DONE.
- One sub-module, if_icache:
  - Valid/tag/data arrays.
  - Combinational lookup (hit, data).
  - Synchronous write port.
  - Synchronous clear on rst.

Test Plan:
- Reset then run, memory at 0..3 = 13,05,10,00:
  - mem_req_o pulses addr 0,1,2,3 on consecutive cycles.
  - DONE 6 cycles after reset release with if_inst_o=32'h0010_0513, if_pc_o=0; pc then advances to 4.
- Jump back to 0 via branch_flag_i, target 0: next cycle is a hit, if_inst_o=32'h0010_0513 with mem_req_o=0 and stallreq_o=0.
- mem_busy_i=1 for 3 cycles while in S2:
  - No issues during those cycles; byte 1 is still captured in the first busy cycle.
  - Fetch resumes at addr pc+2; total latency 9 cycles; word correct.
- branch_flag_i=1, target 32'h100, while in S3:
  - Next cycle S0 with mem_addr_o=32'h100.
  - Stale byte discarded; no cache entry written for the old pc.
- DONE with stall_i[0]=1 for 4 cycles: if_inst_o/if_pc_o stable and pc unchanged; releasing the stall advances pc by 4.
- rst asserted in S2: next cycle state S0, pc=RESET_PC, mem_req_o=0; the former hit address now misses.

Source files
------------

// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_pkg
//  Purpose  : Shared constants, bus widths and fetch-state encoding for the
//             instruction-fetch stage and its instruction cache.
//  Contents : RstEnable, Stop/NoStop, ZeroWord, InstAddrBus/InstBus widths,
//             fetch_state_e (S0..S4, DONE) and small state helper functions.
//  Revision : 1.0  initial release
// ============================================================================
package if_fetch_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        Stop        = 1'b1;
  localparam logic        NoStop      = 1'b0;
  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  // In Sk (k = 0..3) byte k of the word is issued; S4 only waits for the
  // last byte to return; DONE presents the assembled word.
  typedef enum logic [2:0] {
    S0   = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    DONE = 3'd5
  } fetch_state_e;

  // Byte offset (relative to pc) issued while in the given state.
  function automatic logic [InstAddrBus-1:0] issue_offset(input fetch_state_e s);
    case (s)
      S1:      return 32'd1;
      S2:      return 32'd2;
      S3:      return 32'd3;
      default: return 32'd0;
    endcase
  endfunction

  // Buffer byte lane that the returning read lands in while in the given
  // state (one behind the issue index).
  function automatic logic [1:0] capture_lane(input fetch_state_e s);
    case (s)
      S2:      return 2'd1;
      S3:      return 2'd2;
      S4:      return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // State following a granted issue.
  function automatic fetch_state_e issue_next(input fetch_state_e s);
    case (s)
      S0:      return S1;
      S1:      return S2;
      S2:      return S3;
      S3:      return S4;
      default: return s;
    endcase
  endfunction

endpackage : if_fetch_pkg
`default_nettype wire

// File: rtl/if_fetch_icache.sv
`default_nettype none
// ============================================================================
//  Module   : if_icache
//  Purpose  : Direct-mapped, one-word-per-line instruction cache.
//  Ports    : clk, rst        - clock, synchronous active-high clear of valids
//             rd_addr_i       - byte address to look up (combinational)
//             hit_o, rd_data_o- lookup result
//             we_i, wr_addr_i,
//             wr_data_i       - synchronous write port (aligned words only)
//  Revision : 1.0  initial release
// ============================================================================
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:0] rd_addr_i,
  output logic                   hit_o,
  output logic [InstBus-1:0]     rd_data_o,
  input  logic                   we_i,
  input  logic [InstAddrBus-1:0] wr_addr_i,
  input  logic [InstBus-1:0]     wr_data_i
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = InstAddrBus - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [InstBus-1:0] data_q [ENTRIES];

  logic [IDX_W-1:0]   rd_idx;
  logic [TAG_W-1:0]   rd_tag;
  logic [IDX_W-1:0]   wr_idx;
  logic [TAG_W-1:0]   wr_tag;
  logic [1:0]         unused_wr_lo;

  assign rd_idx       = rd_addr_i[IDX_W+1:2];
  assign rd_tag       = rd_addr_i[InstAddrBus-1:IDX_W+2];
  assign wr_idx       = wr_addr_i[IDX_W+1:2];
  assign wr_tag       = wr_addr_i[InstAddrBus-1:IDX_W+2];
  assign unused_wr_lo = wr_addr_i[1:0];

  // Only aligned words are ever stored, so a misaligned pc that shares an
  // index and tag with a cached word must not be served from it.
  assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) &&
                     (rd_addr_i[1:0] == 2'b00);
  assign rd_data_o = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule : if_icache
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch
//  Purpose  : Instruction-fetch stage. Owns the PC, fetches 32-bit
//             little-endian instructions over the shared 8-bit memory port
//             one byte per granted cycle, and short-cuts hits through a
//             direct-mapped instruction cache.
//  Ports    : clk, rst                         - clock, sync active-high reset
//             stall_i[0]                       - hold PC / IF (Stop = 1)
//             branch_flag_i, branch_target_i   - redirect from ID
//             mem_busy_i                       - MEM owns the port this cycle
//             mem_din_i                        - byte returned after an issue
//             mem_req_o, mem_addr_o            - byte read issue
//             if_pc_o, if_inst_o               - presented (pc, instruction)
//             stallreq_o                       - fetch incomplete
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                     ICACHE_IDX_W = 5,
  parameter logic [InstAddrBus-1:0] RESET_PC     = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  input  logic                   mem_busy_i,
  input  logic [7:0]             mem_din_i,
  output logic                   mem_req_o,
  output logic [InstAddrBus-1:0] mem_addr_o,
  output logic [InstAddrBus-1:0] if_pc_o,
  output logic [InstBus-1:0]     if_inst_o,
  output logic                   stallreq_o
);

  fetch_state_e           state_q, state_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [InstBus-1:0]     buf_q, buf_d;
  logic                   inflight_q, inflight_d;
  logic                   fill_q, fill_d;   // first cycle in DONE

  logic                   cache_hit;
  logic [InstBus-1:0]     cache_data;
  logic                   cache_we;
  logic                   unused_stall;

  assign unused_stall = ^stall_i[5:1];

  if_icache #(
    .IDX_W (ICACHE_IDX_W)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_i (pc_q),
    .hit_o     (cache_hit),
    .rd_data_o (cache_data),
    .we_i      (cache_we),
    .wr_addr_i (pc_q),
    .wr_data_i (buf_q)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= S0;
      pc_q       <= RESET_PC;
      buf_q      <= ZeroWord;
      inflight_q <= 1'b0;
      fill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      inflight_q <= inflight_d;
      fill_q     <= fill_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    inflight_d = 1'b0;
    fill_d     = 1'b0;
    cache_we   = 1'b0;
    mem_req_o  = 1'b0;
    mem_addr_o = ZeroWord;
    if_pc_o    = pc_q;
    if_inst_o  = ZeroWord;
    stallreq_o = 1'b0;

    // The byte issued last cycle lands regardless of who owns the port now.
    if (inflight_q) begin
      buf_d[{capture_lane(state_q), 3'b000} +: 8] = mem_din_i;
    end

    case (state_q)
      S0, S1, S2, S3: begin
        if ((state_q == S0) && cache_hit) begin
          if_inst_o = cache_data;
          if (stall_i[0] == NoStop) begin
            pc_d = pc_q + 32'd4;
          end
        end else begin
          stallreq_o = 1'b1;
          if (!mem_busy_i) begin
            mem_req_o  = 1'b1;
            mem_addr_o = pc_q + issue_offset(state_q);
            inflight_d = 1'b1;
            state_d    = issue_next(state_q);
          end
        end
      end
      S4: begin
        stallreq_o = 1'b1;
        state_d    = DONE;
        fill_d     = 1'b1;
      end
      DONE: begin
        if_inst_o = buf_q;
        cache_we  = fill_q && (pc_q[1:0] == 2'b00);
        if (stall_i[0] == NoStop) begin
          pc_d    = pc_q + 32'd4;
          state_d = S0;
        end
      end
      default: begin
        state_d = S0;
      end
    endcase

    // A redirect abandons whatever is in progress, including a pending fill.
    if (branch_flag_i) begin
      pc_d       = branch_target_i;
      state_d    = S0;
      inflight_d = 1'b0;
      fill_d     = 1'b0;
      cache_we   = 1'b0;
    end

    if (rst == RstEnable) begin
      mem_req_o  = 1'b0;
      mem_addr_o = ZeroWord;
      if_pc_o    = ZeroWord;
      if_inst_o  = ZeroWord;
      stallreq_o = 1'b0;
      cache_we   = 1'b0;
    end
  end

endmodule : if_fetch
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch
//  Purpose  : Self-checking bench for if_fetch: directed scenarios followed by
//             randomized stall/busy/branch/reset traffic, compared each cycle
//             against a reference model built from the fetch rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_busy_i;
  logic [7:0]  mem_din_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        stallreq_o;

  always #5 clk = ~clk;

  if_fetch #(
    .ICACHE_IDX_W (5),
    .RESET_PC     (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem_busy_i      (mem_busy_i),
    .mem_din_i       (mem_din_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .stallreq_o      (stallreq_o)
  );

  int checks   = 0;
  int failures = 0;

  // Backing memory: 256 bytes, aliased over the whole address space.
  logic [7:0] mem [256];

  // Reference model. A fetch is described by how many bytes have been
  // issued (0..4) and whether the word has been presented; the expected
  // word is read straight from memory. The cache model remembers which full
  // pc owns each line.
  logic [31:0] m_pc    = 32'h0;
  int          m_n     = 0;
  bit          m_done  = 1'b0;
  bit          m_first = 1'b0;
  bit          m_cv  [32];
  logic [31:0] m_cpc [32];

  logic [31:0] obs_pc, obs_inst, obs_addr;
  logic        obs_req, obs_stall;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mem[a3[7:0]], mem[a2[7:0]], mem[a1[7:0]], mem[a[7:0]]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, compare outputs,
  // then let the rising edge happen, return the memory byte and advance the
  // model.
  task automatic step(input logic r, input logic st, input logic br,
                      input logic [31:0] tgt, input logic busy);
    logic [31:0] e_pc, e_inst, e_addr;
    logic        e_req, e_stall, hit;
    int          idx;
    rst             = r;
    stall_i         = {5'($urandom), st};
    branch_flag_i   = br;
    branch_target_i = tgt;
    mem_busy_i      = busy;
    #1;
    idx = int'(m_pc[6:2]);
    hit = !m_done && (m_n == 0) && (m_pc[1:0] == 2'b00) &&
          m_cv[idx] && (m_cpc[idx] == m_pc);
    e_addr = m_pc + 32'(m_n);
    if (r) begin
      e_pc = 32'h0; e_inst = 32'h0; e_req = 1'b0; e_stall = 1'b0;
    end else if (m_done || hit) begin
      e_pc = m_pc; e_inst = word_at(m_pc); e_req = 1'b0; e_stall = 1'b0;
    end else begin
      e_pc = m_pc; e_inst = 32'h0; e_stall = 1'b1;
      e_req = (m_n < 4) && !busy;
    end
    obs_pc = if_pc_o; obs_inst = if_inst_o; obs_addr = mem_addr_o;
    obs_req = mem_req_o; obs_stall = stallreq_o;
    chk("if_pc", obs_pc, e_pc);
    chk("if_inst", obs_inst, e_inst);
    chk("mem_req", {31'b0, obs_req}, {31'b0, e_req});
    chk("stallreq", {31'b0, obs_stall}, {31'b0, e_stall});
    if (e_req) chk("mem_addr", obs_addr, e_addr);
    if (r) chk("mem_addr_rst", obs_addr, 32'h0);

    @(posedge clk);
    #1;
    mem_din_i = e_req ? mem[e_addr[7:0]] : 8'($urandom);

    if (r) begin
      m_pc = 32'h0; m_n = 0; m_done = 1'b0; m_first = 1'b0;
      for (int i = 0; i < 32; i++) m_cv[i] = 1'b0;
    end else if (br) begin
      m_pc = tgt; m_n = 0; m_done = 1'b0; m_first = 1'b0;
    end else if (m_done) begin
      if (m_first && (m_pc[1:0] == 2'b00)) begin
        m_cv[idx]  = 1'b1;
        m_cpc[idx] = m_pc;
      end
      m_first = 1'b0;
      if (!st) begin
        m_pc = m_pc + 32'd4; m_n = 0; m_done = 1'b0;
      end
    end else if (hit) begin
      if (!st) m_pc = m_pc + 32'd4;
    end else if (m_n == 4) begin
      m_done = 1'b1; m_first = 1'b1;
    end else if (!busy) begin
      m_n++;
    end
    @(negedge clk);
  endtask

  logic [31:0] tgt, held_inst, held_pc;
  int          cyc;

  initial begin
    rst = 1'b1; stall_i = '0; branch_flag_i = 1'b0; branch_target_i = '0;
    mem_busy_i = 1'b0; mem_din_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    for (int i = 0; i < 32; i++) begin m_cv[i] = 1'b0; m_cpc[i] = '0; end
    @(negedge clk);

    // Reset, then the first miss: issues at 0..3, word on the 6th cycle.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0);
      if (i < 4) chk("first_issue_addr", obs_addr, 32'(i));
    end
    chk("first_word", obs_inst, 32'h0010_0513);
    chk("first_pc", obs_pc, 32'h0);

    // Back to 0: immediate hit without touching memory.
    step(0, 0, 1, 32'h0, 0);
    step(0, 1, 0, 0, 0);
    chk("hit_word", obs_inst, 32'h0010_0513);
    chk("hit_req", {31'b0, obs_req}, 32'h0);
    chk("hit_stallreq", {31'b0, obs_stall}, 32'h0);
    step(0, 0, 0, 0, 0);

    // Fetch at 4 with MEM owning the port for 3 cycles in S2.
    cyc = 0;
    do begin
      step(0, 1, 0, 0, (cyc >= 2 && cyc <= 4));
      cyc++;
    end while (obs_stall && cyc < 30);
    chk("busy_latency", 32'(cyc), 32'd9);
    chk("busy_word", obs_inst, word_at(32'h4));

    // DONE held by stall for 4 cycles, then released.
    held_inst = obs_inst;
    held_pc   = obs_pc;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      chk("hold_inst", obs_inst, held_inst);
      chk("hold_pc", obs_pc, held_pc);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("release_pc", obs_pc, 32'h8);

    // Fetch at 8 redirected to 0x100 while in S3; 8 must stay uncached.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h100, 0);
    step(0, 0, 0, 0, 0);
    chk("redirect_req", {31'b0, obs_req}, 32'h1);
    chk("redirect_addr", obs_addr, 32'h100);
    step(0, 0, 1, 32'h8, 0);
    step(0, 0, 0, 0, 0);
    chk("aborted_not_cached", {31'b0, obs_stall}, 32'h1);

    // Reset in S2: cache invalidated, pc 0 now misses.
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("post_rst_miss", {31'b0, obs_stall}, 32'h1);
    chk("post_rst_addr", obs_addr, 32'h0);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      case ($urandom_range(0, 5))
        0:       tgt = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        1:       tgt = (32'($urandom_range(0, 3)) << 7) | 32'($urandom_range(0, 127));
        default: tgt = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 2);
      endcase
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) == 0),
           tgt,
           ($urandom_range(0, 9) < 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_if_fetch
`default_nettype wire
